// File: rtl/sdm_pkg.sv
// Shared types, full-scale constants and the saturating adder for the
// second-order sigma-delta modulator.
package sdm_pkg;

    typedef logic signed [15:0] q15_t;

    // Wide enough for any ACC_W up to 32 plus the feedback swing.
    localparam int unsigned CALC_W = 40;
    typedef logic signed [CALC_W-1:0] calc_t;

    localparam calc_t FS_POS = 40'sd32768;
    localparam calc_t FS_NEG = -40'sd32768;

    typedef struct packed {
        calc_t val;
        logic  clip;
    } sat_res_t;

    function automatic sat_res_t sat_add(input calc_t a, input calc_t b, input int unsigned w);
        sat_res_t r;
        calc_t    s;
        calc_t    hi;
        calc_t    lo;
        s      = a + b;
        hi     = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
        lo     = ~hi;
        r.val  = s;
        r.clip = 1'b0;
        if (s > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (s < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdm_modulator_if.sv
// Sample handshake and bitstream outputs of sdm_modulator, bundled for
// wrappers and benches that connect to its flat ports.
interface sdm_modulator_if;
    sdm_pkg::q15_t in_data;
    logic          in_valid;
    logic          in_ready;
    logic          bit_out;
    logic          bit_valid;
    logic          frame;
    logic          underrun;
    logic          sat;

    modport master (
        output in_data, in_valid,
        input  in_ready, bit_out, bit_valid, frame, underrun, sat
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, bit_out, bit_valid, frame, underrun, sat
    );
endinterface

// File: rtl/sdm_integrator.sv
// ce-gated saturating accumulator: acc <= sat(acc + x - fb); the
// saturated next value is exposed combinationally for the next stage.
module sdm_integrator
    import sdm_pkg::*;
#(
    parameter int unsigned ACC_W = 24
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  ce,
    input  calc_t x_i,
    input  calc_t fb_i,
    output calc_t acc_next_o,
    output logic  sat_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    sat_res_t                res;

    always_comb begin
        res        = sat_add(calc_t'(acc_q), x_i - fb_i, ACC_W);
        acc_d      = res.val[ACC_W-1:0];
        acc_next_o = res.val;
        sat_o      = res.clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (ce) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sdm_modulator.sv
// Second-order 1-bit sigma-delta modulator: one Q15 sample per OSR output
// bits, with a one-entry holding register in front of the active sample.
module sdm_modulator
    import sdm_pkg::*;
#(
    parameter int unsigned OSR   = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  q15_t in_data,
    input  logic in_valid,
    output logic in_ready,
    output logic bit_out,
    output logic bit_valid,
    output logic frame,
    output logic underrun,
    output logic sat
);

    localparam int unsigned     PH_W    = $clog2(OSR);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OSR - 1);

    q15_t            cur_q, cur_d;
    q15_t            next_q, next_d;
    logic            next_full_q, next_full_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            bit_q, bit_d;

    logic  xfer, wrap, consume, sat1, sat2;
    calc_t fb, i1_next, i2_next;

    assign in_ready = ~next_full_q & ~rst;
    assign xfer     = in_valid & in_ready;
    assign wrap     = ce & (phase_q == PH_LAST);
    assign consume  = wrap & next_full_q;
    assign fb       = bit_q ? FS_POS : FS_NEG;

    sdm_integrator #(.ACC_W(ACC_W)) u_int1 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .x_i       (calc_t'(cur_q)),
        .fb_i      (fb),
        .acc_next_o(i1_next),
        .sat_o     (sat1)
    );

    // Second stage integrates the already-saturated first-stage result.
    sdm_integrator #(.ACC_W(ACC_W)) u_int2 (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .x_i       (i1_next),
        .fb_i      (fb),
        .acc_next_o(i2_next),
        .sat_o     (sat2)
    );

    always_comb begin
        next_d      = xfer ? in_data : next_q;
        next_full_d = (next_full_q & ~consume) | xfer;
        cur_d       = consume ? next_q : cur_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        if (ce) begin
            phase_d = wrap ? '0 : phase_q + PH_W'(1);
            bit_d   = (i2_next >= calc_t'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q       <= '0;
            next_q      <= '0;
            next_full_q <= 1'b0;
            phase_q     <= '0;
            bit_q       <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            next_q      <= next_d;
            next_full_q <= next_full_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
        end
    end

    // Status pulses describe the ce cycle in progress; bit_out takes the new
    // value at the edge that closes it.
    assign bit_out   = bit_q;
    assign bit_valid = ce & ~rst;
    assign frame     = ce & ~rst & (phase_q == '0);
    assign underrun  = wrap & ~next_full_q & ~rst;
    assign sat       = ce & ~rst & (sat1 | sat2);

endmodule

// File: tb/tb_sdm_modulator.sv
// Directed bench for sdm_modulator: OSR=16 and OSR=4 instances checked
// against hand-computed values and a behavioural modulator model.
module tb_sdm_modulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce16 = 1'b0;
    logic ce4 = 1'b0;

    always #5 clk = ~clk;

    sdm_modulator_if if16 ();
    sdm_modulator_if if4 ();

    sdm_modulator #(.OSR(16), .ACC_W(24)) u_dut16 (
        .clk(clk), .rst(rst), .ce(ce16),
        .in_data(if16.in_data), .in_valid(if16.in_valid), .in_ready(if16.in_ready),
        .bit_out(if16.bit_out), .bit_valid(if16.bit_valid), .frame(if16.frame),
        .underrun(if16.underrun), .sat(if16.sat)
    );

    sdm_modulator #(.OSR(4), .ACC_W(24)) u_dut4 (
        .clk(clk), .rst(rst), .ce(ce4),
        .in_data(if4.in_data), .in_valid(if4.in_valid), .in_ready(if4.in_ready),
        .bit_out(if4.bit_out), .bit_valid(if4.bit_valid), .frame(if4.frame),
        .underrun(if4.underrun), .sat(if4.sat)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Behavioural second-order modulator, 24-bit integrators.
    localparam longint M_HI = 64'sd8388607;
    localparam longint M_LO = -64'sd8388608;
    longint m_i1, m_i2;
    logic   m_b;

    task automatic m_reset();
        m_i1 = 0;
        m_i2 = 0;
        m_b  = 1'b0;
    endtask

    task automatic m_step(input longint cur, output logic b, output logic clip);
        longint v, s1, s2;
        clip = 1'b0;
        v  = m_b ? 64'sd32768 : -64'sd32768;
        s1 = m_i1 + cur - v;
        if (s1 > M_HI) begin s1 = M_HI; clip = 1'b1; end
        if (s1 < M_LO) begin s1 = M_LO; clip = 1'b1; end
        s2 = m_i2 + s1 - v;
        if (s2 > M_HI) begin s2 = M_HI; clip = 1'b1; end
        if (s2 < M_LO) begin s2 = M_LO; clip = 1'b1; end
        m_i1 = s1;
        m_i2 = s2;
        m_b  = (s2 >= 0);
        b    = m_b;
    endtask

    // Called at a negedge with data inputs already set; returns at the next negedge.
    task automatic cyc(input logic sel4, input logic ce_v,
                       output logic bv, output logic fr, output logic ur,
                       output logic st, output logic bo, output logic rdy);
        if (sel4) ce4 = ce_v; else ce16 = ce_v;
        #1;
        bv  = sel4 ? if4.bit_valid : if16.bit_valid;
        fr  = sel4 ? if4.frame     : if16.frame;
        ur  = sel4 ? if4.underrun  : if16.underrun;
        st  = sel4 ? if4.sat       : if16.sat;
        rdy = sel4 ? if4.in_ready  : if16.in_ready;
        @(posedge clk);
        #1;
        bo = sel4 ? if4.bit_out : if16.bit_out;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce16 = 1'b0;
        ce4 = 1'b0;
        if16.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    // Runs nbits ce=1 cycles on the OSR=16 instance with the sample held
    // on in_valid (or offered only in the first cycle when one_shot).
    task automatic run16(input string tag, input int nbits, input longint smp, input logic one_shot,
                         input int win_lo, input int lo, input int hi, input int exp_ur_first);
        logic bv, fr, ur, st, bo, rdy, mb, mc;
        int ones, seq_err, fr_err, bv_err, ur_first;
        ones = 0; seq_err = 0; fr_err = 0; bv_err = 0; ur_first = -1;
        do_reset();
        if16.in_data = 16'(smp);
        if16.in_valid = 1'b1;
        for (int k = 0; k < nbits; k++) begin
            cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
            if (one_shot) if16.in_valid = 1'b0;
            m_step((k < 16) ? 64'sd0 : smp, mb, mc);
            if (bo !== mb) seq_err++;
            if (fr !== ((k % 16) == 0)) fr_err++;
            if (bv !== 1'b1) bv_err++;
            if (ur && ur_first < 0) ur_first = k;
            if (k >= win_lo && k < win_lo + 256 && bo) ones++;
        end
        check({tag, "_seq"}, seq_err, 0);
        check({tag, "_frame"}, fr_err, 0);
        check({tag, "_bvalid"}, bv_err, 0);
        check({tag, "_density_ok"}, (ones >= lo && ones <= hi), 1);
        check({tag, "_underrun_first"}, ur_first, exp_ur_first);
    endtask

    task automatic test_first_bits();
        logic bv, fr, ur, st, bo, rdy;
        logic [3:0] got;
        do_reset();
        if16.in_data = '0;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
            got[k] = bo;
        end
        check("A_first4_bits", got, 4'b1011);
    endtask

    task automatic test_reset_state();
        logic bv, fr, ur, st, bo, rdy;
        rst = 1'b1;
        if16.in_valid = 1'b1;
        if16.in_data = 16'sd1000;
        cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
        cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
        check("R_in_ready", rdy, 0);
        check("R_pulses", {bv, fr, ur, st}, 0);
        check("R_bit_out", bo, 0);
    endtask

    task automatic test_osr4();
        logic bv, fr, ur, st, bo, rdy, mb, mc;
        logic signed [15:0] samp [12];
        int n_acc, gap_err, fr_err, seq_err;
        samp = '{16'sd1000, -16'sd2000, 16'sd8000, -16'sd16000, 16'sd30000, -16'sd30000,
                 16'sd0, 16'sd12345, -16'sd1, 16'sd20000, 16'sd5000, -16'sd5000};
        n_acc = 0; gap_err = 0; fr_err = 0; seq_err = 0;
        do_reset();
        if4.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if4.in_data = samp[n_acc];
            cyc(1'b1, 1'b1, bv, fr, ur, st, bo, rdy);
            if (rdy) begin
                if ((k % 4) != 0) gap_err++;
                n_acc++;
            end
            m_step((k < 4) ? 64'sd0 : longint'(samp[k / 4 - 1]), mb, mc);
            if (bo !== mb) seq_err++;
            if (fr !== ((k % 4) == 0)) fr_err++;
        end
        check("C_accept_count", n_acc, 10);
        check("C_accept_spacing", gap_err, 0);
        check("C_frame_every4", fr_err, 0);
        check("C_seq", seq_err, 0);
    endtask

    task automatic test_ce_third();
        logic bv, fr, ur, st, bo, rdy, mb, mc;
        int k, seq_err, fr_err, idle_err, bv_cnt;
        k = 0; seq_err = 0; fr_err = 0; idle_err = 0; bv_cnt = 0;
        do_reset();
        if16.in_data = 16'sd16384;
        if16.in_valid = 1'b1;
        for (int c = 0; c < 192; c++) begin
            cyc(1'b0, (c % 3) == 0, bv, fr, ur, st, bo, rdy);
            if ((c % 3) == 0) begin
                m_step((k < 16) ? 64'sd0 : 64'sd16384, mb, mc);
                if (bo !== mb) seq_err++;
                if (fr !== ((k % 16) == 0)) fr_err++;
                if (bv) bv_cnt++;
                k++;
            end else if (bv || fr || ur || st) begin
                idle_err++;
            end
        end
        check("E_seq", seq_err, 0);
        check("E_frame", fr_err, 0);
        check("E_idle_pulses", idle_err, 0);
        check("E_bvalid_count", bv_cnt, 64);
    endtask

    task automatic test_mid_reset();
        logic bv, fr, ur, st, bo, rdy, mb, mc;
        int seq_err, ur_first;
        seq_err = 0; ur_first = -1;
        do_reset();
        if16.in_data = 16'sd16384;
        if16.in_valid = 1'b1;
        for (int k = 0; k < 21; k++) cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
        check("F_next_full_before", rdy, 0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
        check("F_rst_in_ready", rdy, 0);
        check("F_rst_pulses", {bv, fr, ur, st}, 0);
        check("F_rst_bit_out", bo, 0);
        rst = 1'b0;
        if16.in_valid = 1'b0;
        m_reset();
        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
            if (k == 0) begin
                check("F_after_in_ready", rdy, 1);
                check("F_after_frame", fr, 1);
            end
            m_step(64'sd0, mb, mc);
            if (bo !== mb) seq_err++;
            if (ur && ur_first < 0) ur_first = k;
        end
        check("F_seq_cur0", seq_err, 0);
        check("F_underrun_first", ur_first, 15);
    endtask

    task automatic test_sat();
        logic bv, fr, ur, st, bo, rdy, mb, mc;
        int sat_err, sat_cnt;
        sat_err = 0; sat_cnt = 0;
        do_reset();
        if16.in_data = -16'sd32768;
        if16.in_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            cyc(1'b0, 1'b1, bv, fr, ur, st, bo, rdy);
            m_step((k < 16) ? 64'sd0 : -64'sd32768, mb, mc);
            if (st !== mc || bo !== mb) sat_err++;
            if (st) sat_cnt++;
        end
        check("G_sat_track", sat_err, 0);
        check("G_sat_seen", (sat_cnt > 0), 1);
    endtask

    initial begin
        if16.in_data = '0;
        if16.in_valid = 1'b0;
        if4.in_data = '0;
        if4.in_valid = 1'b0;
        @(negedge clk);
        test_reset_state();
        test_first_bits();
        run16("A0",   256,      0, 1'b0, 0,  126, 130, -1);
        run16("Bpos", 272,  16384, 1'b0, 16, 190, 194, -1);
        run16("Bneg", 272, -16384, 1'b0, 16,  62,  66, -1);
        run16("D",    288,  16384, 1'b1, 32, 190, 194, 31);
        test_osr4();
        test_ce_third();
        test_mid_reset();
        test_sat();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sdm_modulator.md
SDM_MODULATOR -- requirements
Module: sdm_modulator

Interface
REQ-001 The block SHALL have parameter OSR, default 16, meaning output bits per input sample (power of two, 2..256).
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning integrator width in bits (20..32).
REQ-003 The block SHALL have port clk  input  1  system clock; one clock, all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port ce  input  1  modulator clock enable; one output bit per ce-high cycle.
REQ-006 The block SHALL have port in_data  input  16  signed Q15 sample.
REQ-007 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-008 The block SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 The block SHALL have port bit_out  output  1  modulated bitstream; 1 = +FS, 0 = -FS.
REQ-010 The block SHALL have port bit_valid  output  1  one-cycle pulse when bit_out is updated.
REQ-011 The block SHALL have port frame  output  1  one-cycle pulse, coincident with bit_valid, on the first bit of each sample period.
REQ-012 The block SHALL have port underrun  output  1  one-cycle pulse when a sample period starts with no new sample available.
REQ-013 The block SHALL have port sat  output  1  one-cycle pulse when either integrator clipped this ce cycle.

Function
REQ-014 The block SHALL use a one-entry input holding register ("next"); in_ready = !next_full && !rst.
REQ-015 A transfer SHALL occur when in_valid && in_ready; next is loaded and next_full set on the following edge.
REQ-016 The block SHALL use a phase counter, 0..OSR-1, which advances only on ce and wraps to 0.
REQ-017 On a ce cycle with phase == OSR-1: if next_full, cur <= next and next_full cleared; otherwise cur is kept and underrun pulses.
REQ-018 If a transfer and a consume coincide, next_full SHALL stay set and next SHALL hold the newly accepted sample.
REQ-019 On each ce cycle the feedback SHALL be v = bit_out ? +32768 : -32768, sign-extended to ACC_W bits.
REQ-020 On each ce cycle the block SHALL compute i1' = sat(i1 + cur - v) and i2' = sat(i2 + i1' - v), then register i1 <= i1' and i2 <= i2'.
REQ-021 On each ce cycle bit_out SHALL be set to (i2' >= 0).
REQ-022 On each ce cycle bit_valid SHALL pulse; frame SHALL pulse when the phase counter held 0 in that ce cycle.
REQ-023 sat() SHALL clip to the signed ACC_W range, [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sat pulses if either operation clipped.
REQ-024 With ce low, all state SHALL hold and bit_valid/frame/underrun/sat SHALL be 0; the input handshake SHALL remain active.
REQ-025 Latency SHALL be: a sample consumed at the wrap edge drives the bit produced on the next ce cycle, which is the frame bit.
REQ-026 The long-run density of ones SHALL equal (cur/32768 + 1)/2.

Reset
REQ-027 While rst is high: i1 = i2 = 0, cur = 0, next = 0, next_full = 0, phase = 0, bit_out = 0, bit_valid = frame = underrun = sat = 0, in_ready = 0.
REQ-028 Reset mid-period SHALL discard cur and next; the first ce cycle after reset SHALL be a frame bit using cur = 0.

Structure
REQ-029 Package sdm_pkg SHALL hold: the q15_t typedef, the FS_POS/FS_NEG constants (+32768/-32768), and the saturating-add function.
REQ-030 A sub-module sdm_integrator (saturating accumulator, ce-gated, with sat flag) SHALL be instantiated twice.

Verification
REQ-031 The bench SHALL cover: OSR=16, cur=0, ce always high, 256 bits -> 128 +/-2 ones.
REQ-032 The bench SHALL cover: cur=+16384 held -> 192 +/-2 ones per 256 bits; cur=-16384 -> 64 +/-2 ones per 256 bits.
REQ-033 The bench SHALL cover: OSR=4, in_valid held high -> one acceptance per 4 ce cycles after the first fill; frame every 4th bit_valid.
REQ-034 The bench SHALL cover: in_valid low for one period -> underrun pulses at the wrap, and the previous sample is reused (bit density unchanged).
REQ-035 The bench SHALL cover: ce toggled 1-in-3 -> bit sequence identical to the ce=1 run; no pulses on ce-low cycles.
REQ-036 The bench SHALL cover: rst asserted mid-period with next_full=1 -> all REQ-027 values next cycle, in_ready=0 during rst and 1 after.
